// File: rtl/uart_pkg.sv
// Shared UART definitions: frame state encoding and default bit timing.
package uart_pkg;

  localparam int unsigned CLKS_PER_BIT_DEFAULT = 868;
  localparam int unsigned DATA_BITS            = 8;

  typedef enum logic [2:0] {
    StIdle,
    StStart,
    StData,
    StParity,
    StStop
  } uart_state_e;

endpackage

// File: rtl/uart_tx_serializer_if.sv
// Byte handshake between the APB/UART interface (master) and the transmit stage (slave).
interface uart_tx_serializer_if;
  import uart_pkg::*;

  logic                 tx_en;
  logic                 txStart;
  logic [DATA_BITS-1:0] txData;
  logic                 txDone;
  logic                 busy;

  modport master (
    output tx_en,
    output txStart,
    output txData,
    input  txDone,
    input  busy
  );

  modport slave (
    input  tx_en,
    input  txStart,
    input  txData,
    output txDone,
    output busy
  );

endinterface

// File: rtl/uart_baud_tick.sv
// Bit-period counter: counts 0..CLKS_PER_BIT-1 while enabled, flags the last cycle of a bit.
module uart_baud_tick #(
  parameter int unsigned CLKS_PER_BIT = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic en,
  input  logic clear,
  output logic bit_end
);

  localparam int unsigned CntW = $clog2(CLKS_PER_BIT);
  localparam logic [CntW-1:0] CntMax = CntW'(CLKS_PER_BIT - 1);

  logic [CntW-1:0] cnt_q, cnt_d;
  logic            wrap;

  assign wrap    = (cnt_q == CntMax);
  assign bit_end = en && !clear && wrap;

  // Next count: synchronous clear wins, otherwise wrap at the end of each bit.
  always_comb begin
    cnt_d = cnt_q;
    if (clear) begin
      cnt_d = '0;
    end else if (en) begin
      cnt_d = wrap ? '0 : cnt_q + CntW'(1);
    end
  end

  // Counter register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/uart_tx_serializer.sv
// UART transmit stage: start bit, 8 data bits LSB first, optional parity, 1 or 2 stop bits.
module uart_tx_serializer
  import uart_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = CLKS_PER_BIT_DEFAULT,
  parameter int unsigned PARITY_EN    = 0,
  parameter int unsigned PARITY_ODD   = 0,
  parameter int unsigned STOP_BITS    = 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  uart_tx_serializer_if.slave  bus,
  output logic                 tx
);

  localparam int unsigned IdxW = $clog2(DATA_BITS);
  localparam logic [IdxW-1:0] LastIdx = IdxW'(DATA_BITS - 1);
  // Index of the final stop bit (0 for one stop bit, 1 for two).
  localparam logic LastStop = (STOP_BITS > 1);

  uart_state_e          state_q, state_d;
  logic [DATA_BITS-1:0] data_q, data_d;
  logic [IdxW-1:0]      bit_idx_q, bit_idx_d;
  logic                 stop_idx_q, stop_idx_d;
  logic                 start_q;
  logic                 accept;
  logic                 bit_end;
  logic                 parity;

  // Only a rising txStart seen in IDLE with the transmitter enabled starts a frame.
  assign accept    = (state_q == StIdle) && bus.tx_en && bus.txStart && !start_q;
  assign parity    = (PARITY_ODD != 0) ? ~^data_q : ^data_q;
  assign bus.busy  = (state_q != StIdle);

  uart_baud_tick #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_baud_tick (
    .clk    (clk),
    .rst_n  (rst_n),
    .en     (state_q != StIdle),
    .clear  (accept),
    .bit_end(bit_end)
  );

  // Frame sequencing, line level and end-of-frame pulse.
  always_comb begin
    state_d    = state_q;
    data_d     = data_q;
    bit_idx_d  = bit_idx_q;
    stop_idx_d = stop_idx_q;
    tx         = 1'b1;
    bus.txDone = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (accept) begin
          state_d    = StStart;
          data_d     = bus.txData;
          bit_idx_d  = '0;
          stop_idx_d = 1'b0;
        end
      end
      StStart: begin
        tx = 1'b0;
        if (bit_end) state_d = StData;
      end
      StData: begin
        tx = data_q[bit_idx_q];
        if (bit_end) begin
          if (bit_idx_q == LastIdx) begin
            state_d = (PARITY_EN != 0) ? StParity : StStop;
          end else begin
            bit_idx_d = bit_idx_q + IdxW'(1);
          end
        end
      end
      StParity: begin
        tx = parity;
        if (bit_end) state_d = StStop;
      end
      StStop: begin
        if (bit_end) begin
          if (stop_idx_q == LastStop) begin
            bus.txDone = 1'b1;
            state_d    = StIdle;
          end else begin
            stop_idx_d = 1'b1;
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // State, latched byte and txStart edge-detect history.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= StIdle;
      data_q     <= '0;
      bit_idx_q  <= '0;
      stop_idx_q <= 1'b0;
      start_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      data_q     <= data_d;
      bit_idx_q  <= bit_idx_d;
      stop_idx_q <= stop_idx_d;
      start_q    <= bus.txStart;
    end
  end

endmodule

// File: tb/tb_uart_tx_serializer.sv
// Directed bench: four DUT variants (plain, even parity, odd parity, two stop bits), CPB=4.
module tb_uart_tx_serializer;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       tx_en = 1'b0;
  logic       tx_start = 1'b0;
  logic [7:0] tx_data = 8'h00;
  logic [3:0] tx_w, done_w, busy_w;

  int n_total = 0;
  int n_pass  = 0;

  always #5 clk = ~clk;

  for (genvar g = 0; g < 4; g++) begin : g_dut
    uart_tx_serializer_if bus ();
    assign bus.tx_en   = tx_en;
    assign bus.txStart = tx_start;
    assign bus.txData  = tx_data;
    assign done_w[g]   = bus.txDone;
    assign busy_w[g]   = bus.busy;

    uart_tx_serializer #(
      .CLKS_PER_BIT(4),
      .PARITY_EN   ((g == 1 || g == 2) ? 1 : 0),
      .PARITY_ODD  ((g == 2) ? 1 : 0),
      .STOP_BITS   ((g == 3) ? 2 : 1)
    ) u_dut (
      .clk  (clk),
      .rst_n(rst_n),
      .bus  (bus.slave),
      .tx   (tx_w[g])
    );
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
  endtask

  function automatic int pe_of(input int sel);
    return (sel == 1 || sel == 2) ? 1 : 0;
  endfunction

  function automatic int po_of(input int sel);
    return (sel == 2) ? 1 : 0;
  endfunction

  function automatic int ns_of(input int sel);
    return (sel == 3) ? 2 : 1;
  endfunction

  // Expected line level for frame bit i.
  function automatic logic exp_bit(input logic [7:0] d, input int sel, input int i);
    if (i == 0) return 1'b0;
    if (i <= 8) return d[i-1];
    if (pe_of(sel) != 0 && i == 9) return (^d) ^ po_of(sel)[0];
    return 1'b1;
  endfunction

  // Raise txStart with byte d and check every cycle of the frame on DUT sel.
  // txStart is left high on return (interface-style hold).
  task automatic send(input int sel, input logic [7:0] d, input string tag);
    int len;
    len = (9 + pe_of(sel) + ns_of(sel)) * 4;
    @(posedge clk); #1;
    tx_data  = d;
    tx_start = 1'b1;
    @(negedge clk);
    check({tag, "_busy_accept_cycle"}, busy_w[sel], 1'b0);
    for (int k = 1; k <= len; k++) begin
      @(negedge clk);
      check($sformatf("%s_tx_c%0d", tag, k), tx_w[sel], exp_bit(d, sel, (k - 1) / 4));
      check($sformatf("%s_busy_c%0d", tag, k), busy_w[sel], 1'b1);
      check($sformatf("%s_done_c%0d", tag, k), done_w[sel], (k == len) ? 1'b1 : 1'b0);
    end
    @(negedge clk);
    check({tag, "_post_tx"}, tx_w[sel], 1'b1);
    check({tag, "_post_busy"}, busy_w[sel], 1'b0);
    check({tag, "_post_done"}, done_w[sel], 1'b0);
  endtask

  task automatic check_idle(input int sel, input int cycles, input string tag);
    for (int k = 0; k < cycles; k++) begin
      @(negedge clk);
      check({tag, "_idle_busy"}, busy_w[sel], 1'b0);
      check({tag, "_idle_tx"}, tx_w[sel], 1'b1);
    end
  endtask

  task automatic wait_idle();
    int n = 0;
    while (busy_w != 4'h0 && n < 200) begin
      @(negedge clk);
      n++;
    end
    check("wait_idle", busy_w, 4'h0);
  endtask

  task automatic drop_start();
    @(posedge clk); #1;
    tx_start = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b1;
    #2 rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("reset_tx", tx_w, 4'hF);
    check("reset_busy", busy_w, 4'h0);
    check("reset_done", done_w, 4'h0);
    rst_n = 1'b1;
    tx_en = 1'b1;

    // 1: basic frame
    send(0, 8'hA5, "t1");
    drop_start();
    wait_idle();

    // 2: parity variants and two stop bits
    send(1, 8'h07, "t2_even");
    drop_start();
    wait_idle();
    send(2, 8'h07, "t2_odd");
    drop_start();
    wait_idle();
    send(3, 8'h07, "t2_stop2");
    drop_start();
    wait_idle();

    // 3: held txStart must not retrigger
    send(0, 8'h5A, "t3a");
    check_idle(0, 30, "t3_held");
    drop_start();
    send(0, 8'h3C, "t3b");
    drop_start();
    wait_idle();

    // 4: mid-frame txStart edge, txData change, tx_en drop
    fork
      send(0, 8'h5A, "t4a");
      begin
        @(posedge clk);
        repeat (10) @(posedge clk);
        #1 tx_start = 1'b0;
        @(posedge clk);
        #1 tx_start = 1'b1;
        tx_data = 8'hFF;
        repeat (5) @(posedge clk);
        #1 tx_en = 1'b0;
      end
    join
    drop_start();
    @(posedge clk); #1 tx_start = 1'b1;
    check_idle(0, 20, "t4_en_low");
    tx_en = 1'b1;
    check_idle(0, 10, "t4_en_held");
    drop_start();
    send(0, 8'hC3, "t4c");
    drop_start();
    wait_idle();

    // txStart rising in the txDone cycle is ignored
    fork
      send(0, 8'h81, "t_edge_done");
      begin
        @(posedge clk);
        repeat (4) @(posedge clk);
        #1 tx_start = 1'b0;
        repeat (36) @(posedge clk);
        #1 tx_start = 1'b1;
      end
    join
    check_idle(0, 20, "t_edge_done");
    drop_start();
    wait_idle();

    // 5: asynchronous reset during data bit 3
    @(posedge clk); #1;
    tx_data  = 8'h96;
    tx_start = 1'b1;
    repeat (17) @(posedge clk);
    #3;
    check("t5_bit3_tx", tx_w[0], 1'b0);
    rst_n    = 1'b0;
    tx_start = 1'b0;
    #1;
    check("t5_rst_tx", tx_w[0], 1'b1);
    check("t5_rst_busy", busy_w[0], 1'b0);
    check("t5_rst_done", done_w[0], 1'b0);
    @(posedge clk); #1 rst_n = 1'b1;
    check_idle(0, 30, "t5_release");
    send(0, 8'h96, "t5b");
    drop_start();
    wait_idle();

    // 6: back-to-back handshake
    send(0, 8'h11, "t6_0");
    drop_start();
    send(0, 8'h22, "t6_1");
    drop_start();
    send(0, 8'h33, "t6_2");
    drop_start();
    send(0, 8'h44, "t6_3");
    drop_start();
    wait_idle();

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
